// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: MDop encodings, FSM state
// codes and default latencies. The E-stage controller and the hazard unit
// import the same package so the opcode map stays in one place.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_MFHI  = 3'b110;
    localparam logic [2:0] MD_MFLO  = 3'b111;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Bit 1 of a started op distinguishes divides from multiplies.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_datapath.sv
// md_datapath: purely combinational arithmetic on the latched operands.
// Produces the 64-bit product and the 32-bit quotient/remainder for the
// operation held in the unit; the FSM decides when to commit them.
module md_datapath
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    // Extending both operands to 64 bits lets one truncated multiply serve
    // both signed and unsigned products.
    assign a_ext   = is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign b_ext   = is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign product = a_ext * b_ext;

    // Signed divide is done on magnitudes, then signs are restored: the
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
    assign a_neg       = is_signed & op_a[31];
    assign b_neg       = is_signed & op_b[31];
    assign a_mag       = a_neg ? (32'd0 - op_a) : op_a;
    assign b_mag       = b_neg ? (32'd0 - op_b) : op_b;
    assign div_by_zero = (op_b == 32'd0);
    // Keep the divider well defined on zero; its result is discarded anyway.
    assign divisor     = div_by_zero ? 32'd1 : b_mag;
    assign q_mag       = a_mag / divisor;
    assign r_mag       = a_mag % divisor;
    assign quotient    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign remainder   = a_neg ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide responder holding HI/LO.
// Runs mult/multu/div/divu over a fixed latency, handles mthi/mtlo writes,
// and serves mfhi/mflo through the combinational MDout mux.
// Optional feature: define MD_CANCEL_EN to add the md_cancel flush input.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDstart,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MD_CANCEL_EN
    input  logic        md_cancel,
`endif
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t        state_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] count_reg;
    logic [2:0]       op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    logic [63:0]      product;
    logic [31:0]      quotient;
    logic [31:0]      remainder;
    logic             div_by_zero;
    logic             cancel;

`ifdef MD_CANCEL_EN
    assign cancel = md_cancel;
`else
    assign cancel = 1'b0;
`endif

    md_datapath u_datapath (
        .op          (op_reg),
        .op_a        (a_reg),
        .op_b        (b_reg),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Control FSM, latency counter, latched operands and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            op_reg    <= MD_MFLO;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!cancel) begin
                        if (MDstart && !MDop[2]) begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                            op_reg    <= MDop;
                            a_reg     <= A;
                            b_reg     <= B;
                            count_reg <= is_div_op(MDop) ? CNT_W'(DIV_CYCLES)
                                                         : CNT_W'(MULT_CYCLES);
                        end else if (!MDstart && MDop == MD_MTHI) begin
                            hi_reg <= A;
                        end else if (!MDstart && MDop == MD_MTLO) begin
                            lo_reg <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // New requests are ignored here; upstream stalls on md_stall.
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                    end else if (count_reg == CNT_W'(1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                        if (is_div_op(op_reg)) begin
                            if (!div_by_zero) begin
                                hi_reg <= remainder;
                                lo_reg <= quotient;
                            end
                        end else begin
                            hi_reg <= product[63:32];
                            lo_reg <= product[31:0];
                        end
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign md_stall = MDstart | busy_reg;
    assign HI       = hi_reg;
    assign LO       = lo_reg;
    assign MDout    = (MDop == MD_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed scenarios plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDstart;
    logic [2:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MD_CANCEL_EN
    logic        md_cancel;
`endif
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .MDstart  (MDstart),
        .MDop     (MDop),
        .A        (A),
        .B        (B),
`ifdef MD_CANCEL_EN
        .md_cancel(md_cancel),
`endif
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO),
        .MDout    (MDout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural effect of one completed operation.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                p = 64'(sa * sb);
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd1: begin
                p = 64'(a) * 64'(b);
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                lo_m = q[31:0]; hi_m = r[31:0];
            end
            3'd3: if (b != 0) begin
                lo_m = a / b; hi_m = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic idle_cycle();
        MDstart = 1'b0; MDop = 3'b111;
        @(posedge clk); #1;
    endtask

    task automatic check_regs(input string name);
        tests_run++;
        if (HI !== hi_m) begin
            tests_failed++;
            $display("FAIL %s HI: got %h expected %h", name, HI, hi_m);
        end
        tests_run++;
        if (LO !== lo_m) begin
            tests_failed++;
            $display("FAIL %s LO: got %h expected %h", name, LO, lo_m);
        end
    endtask

    // mthi/mtlo issued while idle: single-cycle write, busy stays low.
    task automatic do_move(input logic [2:0] op, input logic [31:0] val);
        MDstart = 1'b0; MDop = op; A = val;
        @(posedge clk); #1;
        if (op == 3'b100) hi_m = val; else lo_m = val;
        MDop = 3'b111;
        $display("[TB] move op=%0d val=%h -> HI=%h LO=%h", op, val, HI, LO);
        check_regs("move");
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL move busy: got %b expected 0", busy);
        end
    endtask

    // Start an op, count busy cycles, then compare HI/LO/MDout to the model.
    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int exp_n;
        exp_n = op[1] ? DIV_N : MULT_N;
        MDstart = 1'b1; MDop = op; A = a; B = b;
        #1;
        tests_run++;
        if (md_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s md_stall on start: got %b expected 1", name, md_stall);
        end
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b111; A = $urandom; B = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            tests_run++;
            if (HI !== hi_m || LO !== lo_m || md_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s in-flight: HI=%h LO=%h stall=%b expected HI=%h LO=%h stall=1",
                         name, HI, LO, md_stall, hi_m, lo_m);
            end
            @(posedge clk); #1;
            cycles++;
        end
        model_apply(op, a, b);
        $display("[TB] %s op=%0d A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", name, op, a, b, HI, LO, cycles);
        tests_run++;
        if (cycles != exp_n) begin
            tests_failed++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, cycles, exp_n);
        end
        check_regs(name);
        MDop = 3'b110; #1;
        tests_run++;
        if (MDout !== hi_m) begin
            tests_failed++;
            $display("FAIL %s MDout mfhi: got %h expected %h", name, MDout, hi_m);
        end
        MDop = 3'b111; #1;
        tests_run++;
        if (MDout !== lo_m || md_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s MDout mflo/stall: got %h/%b expected %h/0", name, MDout, md_stall, lo_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MDstart = 1'b0; MDop = 3'b111; A = '0; B = '0;
`ifdef MD_CANCEL_EN
        md_cancel = 1'b0;
`endif
        hi_m = '0; lo_m = '0;
        #1;
        $display("[TB] reset -> busy=%b HI=%h LO=%h", busy, HI, LO);
        tests_run++;
        if (busy !== 1'b0 || md_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset busy/stall: got %b/%b expected 0/0", busy, md_stall);
        end
        check_regs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset_mid_run();
        do_move(3'b100, 32'hAAAA5555);
        MDstart = 1'b1; MDop = 3'b000; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b111;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        hi_m = '0; lo_m = '0;
        $display("[TB] reset mid-run -> busy=%b HI=%h LO=%h", busy, HI, LO);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid busy: got %b expected 0", busy);
        end
        check_regs("reset_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) idle_cycle();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid late busy: got %b expected 0", busy);
        end
        check_regs("reset_mid_late");
    endtask

    task automatic test_mult();
        run_and_check("mult", 3'd0, 32'hFFFFFFFF, 32'd2);
        run_and_check("multu", 3'd1, 32'hFFFFFFFF, 32'd2);
        run_and_check("mult_neg", 3'd0, 32'h80000000, 32'h80000000);
    endtask

    task automatic test_div();
        run_and_check("div", 3'd2, 32'hFFFFFFF9, 32'd2);
        run_and_check("divu", 3'd3, 32'd7, 32'd2);
        run_and_check("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE);
        run_and_check("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    endtask

    task automatic test_div_zero();
        do_move(3'b100, 32'd5);
        do_move(3'b101, 32'd6);
        run_and_check("divu_zero", 3'd3, 32'd1234, 32'd0);
        run_and_check("div_zero", 3'd2, 32'hFFFF0000, 32'd0);
        do_move(3'b100, 32'h1234);
    endtask

    task automatic test_ignored_start();
        MDstart = 1'b1; MDop = 3'b100; A = 32'h99999999;
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b111;
        $display("[TB] MDstart with mthi -> busy=%b HI=%h", busy, HI);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_start busy: got %b expected 0", busy);
        end
        check_regs("ignored_start");
    endtask

    task automatic test_busy_ignore();
        int cycles;
        MDstart = 1'b1; MDop = 3'd2; A = 32'd1000; B = 32'd7;
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b111;
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            if (cycles == 2) begin
                MDstart = 1'b1; MDop = 3'd0; A = 32'd5; B = 32'd5;
            end else if (cycles == 3) begin
                MDstart = 1'b0; MDop = 3'b101; A = 32'hDEAD;
            end else begin
                MDstart = 1'b0; MDop = 3'b111;
            end
            #1;
            tests_run++;
            if (md_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy_ignore md_stall: got %b expected 1 at cycle %0d", md_stall, cycles);
            end
            @(posedge clk); #1;
            cycles++;
        end
        MDstart = 1'b0; MDop = 3'b111;
        model_apply(3'd2, 32'd1000, 32'd7);
        $display("[TB] busy_ignore div 1000/7 -> HI=%h LO=%h busy_cycles=%0d", HI, LO, cycles);
        tests_run++;
        if (cycles != DIV_N) begin
            tests_failed++;
            $display("FAIL busy_ignore cycles: got %0d expected %0d", cycles, DIV_N);
        end
        check_regs("busy_ignore");
        idle_cycle();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore restart: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_and_check("random", op, a, b);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

`ifdef MD_CANCEL_EN
    task automatic test_cancel();
        MDstart = 1'b1; MDop = 3'd2; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b111;
        repeat (3) begin @(posedge clk); #1; end
        md_cancel = 1'b1;
        @(posedge clk); #1;
        md_cancel = 1'b0;
        $display("[TB] cancel div 100/3 -> busy=%b HI=%h LO=%h", busy, HI, LO);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel busy: got %b expected 0", busy);
        end
        repeat (12) idle_cycle();
        check_regs("cancel");
        MDstart = 1'b1; MDop = 3'd0; A = 32'd9; B = 32'd9; md_cancel = 1'b1;
        @(posedge clk); #1;
        MDstart = 1'b0; MDop = 3'b100; A = 32'h0BAD0BAD;
        @(posedge clk); #1;
        md_cancel = 1'b0; MDop = 3'b111;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_start busy: got %b expected 0", busy);
        end
        check_regs("cancel_move");
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_run();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_busy_ignore();
        test_random();
`ifdef MD_CANCEL_EN
        test_cancel();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
